// File: rtl/stream_queue_if.sv
// Valid/ready message stream bundle shared by producer and consumer sides.
// The master drives msg/val and samples rdy; the slave does the reverse.
interface stream_if #(
    parameter type t_msg = logic [31:0]
);
    t_msg msg;
    logic val;
    logic rdy;

    modport master (output msg, output val, input rdy);
    modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/stream_queue.sv
// Parameterised val/rdy message queue. It decouples a producer from a consumer
// and absorbs consumer back-pressure. With p_bypass=1, a message offered to an
// empty queue is forwarded to the output in the same cycle.
module stream_queue #(
    parameter type t_msg    = logic [31:0],
    parameter int  p_depth  = 4,
    parameter bit  p_bypass = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    stream_if.slave                      istream,
    stream_if.master                     ostream,
    output logic [$clog2(p_depth+1)-1:0] count
);
    localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CNT_W = $clog2(p_depth + 1);

    generate
        if (p_depth < 1) begin : g_bad_depth
            $error("stream_queue: p_depth must be >= 1");
        end
    endgenerate

    t_msg             mem [p_depth];
    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;
    logic             bypass_hit;
    logic             push;
    logic             pop;

    // Explicit wrap so depths that are not a power of two stay in range.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(p_depth - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(p_depth));

    // Ready depends only on occupancy, never on the consumer's ready.
    assign istream.rdy = !full;
    assign ostream.val = !empty || (p_bypass && istream.val);
    assign ostream.msg = empty ? istream.msg : mem[deq_ptr];

    assign enq        = istream.val && istream.rdy;
    assign deq        = ostream.val && ostream.rdy;
    // A message that passes straight through an empty queue is never stored.
    assign bypass_hit = empty && enq && deq;
    assign push       = enq && !bypass_hit;
    assign pop        = deq && !bypass_hit;

    // Occupancy and pointer bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            enq_ptr <= '0;
            deq_ptr <= '0;
        end else begin
            if (push)
                enq_ptr <= next_ptr(enq_ptr);
            if (pop)
                deq_ptr <= next_ptr(deq_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Entry storage: payload captured only on a stored enqueue, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < p_depth; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[enq_ptr] <= istream.msg;
        end
    end
endmodule

// File: tb/tb_stream_queue.sv
// Directed bench for stream_queue: a non-bypass instance (dut0) and a bypass
// instance (dut1), both four entries deep.
module tb_stream_queue;
    logic       clk;
    logic       rst;
    logic [2:0] cnt0;
    logic [2:0] cnt1;
    int         n_cmp;
    int         n_err;

    stream_if #(.t_msg(logic [31:0])) s0_in ();
    stream_if #(.t_msg(logic [31:0])) s0_out ();
    stream_if #(.t_msg(logic [31:0])) s1_in ();
    stream_if #(.t_msg(logic [31:0])) s1_out ();

    stream_queue #(.t_msg(logic [31:0]), .p_depth(4), .p_bypass(1'b0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .istream (s0_in),
        .ostream (s0_out),
        .count   (cnt0)
    );

    stream_queue #(.t_msg(logic [31:0]), .p_depth(4), .p_bypass(1'b1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .istream (s1_in),
        .ostream (s1_out),
        .count   (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        s0_in.val  = 1'b0;
        s0_in.msg  = '0;
        s0_out.rdy = 1'b1;
        s1_in.val  = 1'b0;
        s1_in.msg  = '0;
        s1_out.rdy = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        s0_out.rdy = 1'b0;
        s0_in.msg  = 32'h1;
        s0_in.val  = 1'b1;
        @(negedge clk);
        s0_in.msg  = 32'h2;
        @(negedge clk);
        s0_in.val  = 1'b0;
        #1;
        n_cmp++;
        if (cnt0 !== 3'd2) begin
            n_err++; $display("FAIL reset_pre_count: got %0d expected 2", cnt0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (s0_in.rdy !== 1'b1) begin
            n_err++; $display("FAIL reset_irdy: got %b expected 1", s0_in.rdy);
        end
        n_cmp++;
        if (s0_out.val !== 1'b0) begin
            n_err++; $display("FAIL reset_oval: got %b expected 0", s0_out.val);
        end
        n_cmp++;
        if (cnt0 !== 3'd0) begin
            n_err++; $display("FAIL reset_count: got %0d expected 0", cnt0);
        end
        @(negedge clk);
        rst = 1'b0;
        s0_out.rdy = 1'b1;
    endtask

    task automatic test_stream();
        int tx = 0;
        int rx = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx < 16) begin
                s0_in.val = 1'b1;
                s0_in.msg = 32'(tx);
            end else begin
                s0_in.val = 1'b0;
            end
            #1;
            if (c == 0) begin
                n_cmp++;
                if (s0_out.val !== 1'b0) begin
                    n_err++; $display("FAIL stream_no_bypass: got val %b expected 0", s0_out.val);
                end
            end
            if (c >= 1 && c <= 16) begin
                n_cmp++;
                if (s0_out.val !== 1'b1) begin
                    n_err++; $display("FAIL stream_val c=%0d: got %b expected 1", c, s0_out.val);
                end
            end
            n_cmp++;
            if (cnt0 > 3'd1) begin
                n_err++; $display("FAIL stream_count c=%0d: got %0d expected <=1", c, cnt0);
            end
            if (s0_out.val === 1'b1) begin
                n_cmp++;
                if (s0_out.msg !== 32'(rx)) begin
                    n_err++; $display("FAIL stream_msg: got %h expected %h", s0_out.msg, 32'(rx));
                end
                rx++;
            end
            if (s0_in.val && s0_in.rdy) tx++;
        end
        n_cmp++;
        if (rx != 16) begin
            n_err++; $display("FAIL stream_total: got %0d expected 16", rx);
        end
    endtask

    task automatic test_fill();
        int rx = 0;
        bit sent4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s0_out.rdy = 1'b0;
            s0_in.val  = 1'b1;
            s0_in.msg  = 32'hA0 + 32'(k);
            #1;
            n_cmp++;
            if (s0_in.rdy !== 1'b1) begin
                n_err++; $display("FAIL fill_irdy k=%0d: got %b expected 1", k, s0_in.rdy);
            end
        end
        @(negedge clk);
        s0_in.msg = 32'hA4;
        #1;
        n_cmp++;
        if (cnt0 !== 3'd4) begin
            n_err++; $display("FAIL fill_count: got %0d expected 4", cnt0);
        end
        n_cmp++;
        if (s0_in.rdy !== 1'b0) begin
            n_err++; $display("FAIL fill_full_rdy: got %b expected 0", s0_in.rdy);
        end
        n_cmp++;
        if (s0_out.msg !== 32'hA0) begin
            n_err++; $display("FAIL fill_head: got %h expected a0", s0_out.msg);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (cnt0 !== 3'd4 || s0_out.msg !== 32'hA0) begin
            n_err++; $display("FAIL fill_stall: got count %0d head %h expected 4 a0", cnt0, s0_out.msg);
        end
        for (int c = 0; c < 20 && rx < 5; c++) begin
            @(negedge clk);
            s0_out.rdy = 1'b1;
            if (sent4) s0_in.val = 1'b0;
            #1;
            if (c == 0) begin
                n_cmp++;
                if (s0_in.rdy !== 1'b0) begin
                    n_err++; $display("FAIL fill_full_deq_rdy: got %b expected 0", s0_in.rdy);
                end
            end
            if (s0_out.val === 1'b1) begin
                n_cmp++;
                if (s0_out.msg !== 32'hA0 + 32'(rx)) begin
                    n_err++; $display("FAIL fill_msg: got %h expected %h", s0_out.msg, 32'hA0 + 32'(rx));
                end
                rx++;
            end
            if (s0_in.val && s0_in.rdy) sent4 = 1'b1;
        end
        s0_in.val = 1'b0;
        n_cmp++;
        if (rx != 5) begin
            n_err++; $display("FAIL fill_total: got %0d expected 5", rx);
        end
    endtask

    task automatic test_wrap();
        int tx = 0;
        int rx = 0;
        int dly = 3;
        for (int c = 0; c < 600 && rx < 40; c++) begin
            @(negedge clk);
            s0_out.rdy = (dly == 0);
            if (tx < 40) begin
                s0_in.val = 1'b1;
                s0_in.msg = 32'(tx);
            end else begin
                s0_in.val = 1'b0;
            end
            #1;
            n_cmp++;
            if (cnt0 > 3'd4) begin
                n_err++; $display("FAIL wrap_count: got %0d expected <=4", cnt0);
            end
            if (s0_out.val === 1'b1 && s0_out.rdy) begin
                n_cmp++;
                if (s0_out.msg !== 32'(rx)) begin
                    n_err++; $display("FAIL wrap_msg: got %h expected %h", s0_out.msg, 32'(rx));
                end
                rx++;
                dly = 3;
            end else if (dly > 0) begin
                dly--;
            end
            if (s0_in.val && s0_in.rdy) tx++;
        end
        @(negedge clk);
        s0_in.val  = 1'b0;
        s0_out.rdy = 1'b1;
        #1;
        n_cmp++;
        if (rx != 40) begin
            n_err++; $display("FAIL wrap_total: got %0d expected 40", rx);
        end
        n_cmp++;
        if (cnt0 !== 3'd0 || s0_out.val !== 1'b0) begin
            n_err++; $display("FAIL wrap_drained: got count %0d val %b expected 0 0", cnt0, s0_out.val);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        s1_out.rdy = 1'b1;
        s1_in.msg  = 32'hBEEF;
        s1_in.val  = 1'b1;
        #1;
        n_cmp++;
        if (s1_out.val !== 1'b1 || s1_out.msg !== 32'hBEEF) begin
            n_err++; $display("FAIL bypass_same_cycle: got val %b msg %h expected 1 beef", s1_out.val, s1_out.msg);
        end
        n_cmp++;
        if (cnt1 !== 3'd0) begin
            n_err++; $display("FAIL bypass_count_pre: got %0d expected 0", cnt1);
        end
        @(negedge clk);
        s1_in.val = 1'b0;
        #1;
        n_cmp++;
        if (cnt1 !== 3'd0 || s1_out.val !== 1'b0) begin
            n_err++; $display("FAIL bypass_not_stored: got count %0d val %b expected 0 0", cnt1, s1_out.val);
        end
        @(negedge clk);
        s1_out.rdy = 1'b0;
        s1_in.msg  = 32'h1234;
        s1_in.val  = 1'b1;
        #1;
        n_cmp++;
        if (s1_out.val !== 1'b1 || s1_out.msg !== 32'h1234) begin
            n_err++; $display("FAIL bypass_stall_view: got val %b msg %h expected 1 1234", s1_out.val, s1_out.msg);
        end
        @(negedge clk);
        s1_in.val = 1'b0;
        s1_in.msg = 32'h9999;
        #1;
        n_cmp++;
        if (cnt1 !== 3'd1 || s1_out.msg !== 32'h1234) begin
            n_err++; $display("FAIL bypass_stored: got count %0d msg %h expected 1 1234", cnt1, s1_out.msg);
        end
        @(negedge clk);
        s1_out.rdy = 1'b1;
        #1;
        n_cmp++;
        if (s1_out.val !== 1'b1) begin
            n_err++; $display("FAIL bypass_drain_val: got %b expected 1", s1_out.val);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (cnt1 !== 3'd0) begin
            n_err++; $display("FAIL bypass_drain_count: got %0d expected 0", cnt1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        s0_out.rdy = 1'b0;
        s0_in.val  = 1'b1;
        s0_in.msg  = 32'h11;
        @(negedge clk);
        s0_in.msg  = 32'h22;
        @(negedge clk);
        s0_in.msg  = 32'h33;
        @(negedge clk);
        s0_in.val  = 1'b0;
        #1;
        n_cmp++;
        if (cnt0 !== 3'd3) begin
            n_err++; $display("FAIL rstmid_pre_count: got %0d expected 3", cnt0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (cnt0 !== 3'd0 || s0_out.val !== 1'b0) begin
            n_err++; $display("FAIL rstmid_clear: got count %0d val %b expected 0 0", cnt0, s0_out.val);
        end
        @(negedge clk);
        rst = 1'b0;
        s0_out.rdy = 1'b1;
        s0_in.msg  = 32'h55;
        s0_in.val  = 1'b1;
        @(negedge clk);
        s0_in.val  = 1'b0;
        #1;
        n_cmp++;
        if (s0_out.val !== 1'b1 || s0_out.msg !== 32'h55) begin
            n_err++; $display("FAIL rstmid_first: got val %b msg %h expected 1 55", s0_out.val, s0_out.msg);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (cnt0 !== 3'd0 || s0_out.val !== 1'b0) begin
            n_err++; $display("FAIL rstmid_after: got count %0d val %b expected 0 0", cnt0, s0_out.val);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_stream();
        test_fill();
        test_wrap();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
